// File: rtl/proc_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : proc_alu_pkg
// Purpose  : Shared definitions for the proc ALU stream pipeline.
//            - ALU function-code encodings (6-bit fn field)
//            - helpers sizing the request/response stream messages
//            - helper packing the comparison flags into the response header
// Config   : ALU_SUBWORD_EN gives codes 16..19 (packed lane ops) meaning;
//            the encodings are always declared here.
// Revision : 1.0 - initial release
// ============================================================================
package proc_alu_pkg;

    localparam int ALU_FN_W = 6;

    localparam logic [ALU_FN_W-1:0] ALU_FN_ADD    = 6'd0;
    localparam logic [ALU_FN_W-1:0] ALU_FN_SUB    = 6'd1;
    localparam logic [ALU_FN_W-1:0] ALU_FN_SLL    = 6'd2;
    localparam logic [ALU_FN_W-1:0] ALU_FN_OR     = 6'd3;
    localparam logic [ALU_FN_W-1:0] ALU_FN_SLT    = 6'd4;
    localparam logic [ALU_FN_W-1:0] ALU_FN_SLTU   = 6'd5;
    localparam logic [ALU_FN_W-1:0] ALU_FN_AND    = 6'd6;
    localparam logic [ALU_FN_W-1:0] ALU_FN_XOR    = 6'd7;
    localparam logic [ALU_FN_W-1:0] ALU_FN_NOR    = 6'd8;
    localparam logic [ALU_FN_W-1:0] ALU_FN_SRL    = 6'd9;
    localparam logic [ALU_FN_W-1:0] ALU_FN_SRA    = 6'd10;
    localparam logic [ALU_FN_W-1:0] ALU_FN_CP_OP0 = 6'd11;
    localparam logic [ALU_FN_W-1:0] ALU_FN_CP_OP1 = 6'd12;
    localparam logic [ALU_FN_W-1:0] ALU_FN_PADDB  = 6'd16;
    localparam logic [ALU_FN_W-1:0] ALU_FN_PADDH  = 6'd17;
    localparam logic [ALU_FN_W-1:0] ALU_FN_PSUBB  = 6'd18;
    localparam logic [ALU_FN_W-1:0] ALU_FN_PSUBH  = 6'd19;

    // Request message: {fn, in0, in1}
    function automatic int req_msg_w(input int nbits);
        return 2 * nbits + ALU_FN_W;
    endfunction

    // Response message: {ops_eq, ops_lt, ops_ltu, out}
    function automatic int resp_msg_w(input int nbits);
        return nbits + 3;
    endfunction

    function automatic logic [2:0] pack_flags(input logic eq, input logic lt,
                                              input logic ltu);
        return {eq, lt, ltu};
    endfunction

endpackage
`default_nettype wire

// File: rtl/proc_alu_core.sv
`default_nettype none
// ============================================================================
// Module   : proc_alu_core
// Purpose  : Purely combinational proc ALU. Flags are computed for every op
//            regardless of fn; undefined fn codes produce out = 0.
// Ports    : in0, in1 [P_NBITS]  operands
//            fn       [6]        function code (see proc_alu_pkg)
//            out      [P_NBITS]  result (modular wrap)
//            ops_eq / ops_lt / ops_ltu  equal / signed-less / unsigned-less
// Config   : ALU_SUBWORD_EN adds PADDB/PADDH/PSUBB/PSUBH lane-wise ops
//            (lanes wrap independently, no carry across lanes).
// Revision : 1.0 - initial release
// ============================================================================
module proc_alu_core
    import proc_alu_pkg::*;
#(
    parameter int P_NBITS = 32
) (
    input  logic [P_NBITS-1:0]  in0,
    input  logic [P_NBITS-1:0]  in1,
    input  logic [ALU_FN_W-1:0] fn,
    output logic [P_NBITS-1:0]  out,
    output logic                ops_eq,
    output logic                ops_lt,
    output logic                ops_ltu
);

    localparam int c_SHAMT_W = $clog2(P_NBITS);

    logic [c_SHAMT_W-1:0] w_shamt;

    assign w_shamt = in1[c_SHAMT_W-1:0];
    assign ops_eq  = (in0 == in1);
    assign ops_lt  = ($signed(in0) < $signed(in1));
    assign ops_ltu = (in0 < in1);

`ifdef ALU_SUBWORD_EN
    logic [P_NBITS-1:0] w_paddb;
    logic [P_NBITS-1:0] w_psubb;
    logic [P_NBITS-1:0] w_paddh;
    logic [P_NBITS-1:0] w_psubh;

    // Each lane is an independent adder so carries never leak across lanes.
    for (genvar i = 0; i < P_NBITS / 8; i++) begin : g_lane_b
        assign w_paddb[8*i +: 8] = in0[8*i +: 8] + in1[8*i +: 8];
        assign w_psubb[8*i +: 8] = in0[8*i +: 8] - in1[8*i +: 8];
    end

    for (genvar i = 0; i < P_NBITS / 16; i++) begin : g_lane_h
        assign w_paddh[16*i +: 16] = in0[16*i +: 16] + in1[16*i +: 16];
        assign w_psubh[16*i +: 16] = in0[16*i +: 16] - in1[16*i +: 16];
    end
`endif

    always_comb begin
        out = '0;
        case (fn)
            ALU_FN_ADD:    out = in0 + in1;
            ALU_FN_SUB:    out = in0 - in1;
            ALU_FN_SLL:    out = in0 << w_shamt;
            ALU_FN_OR:     out = in0 | in1;
            ALU_FN_SLT:    out = {{(P_NBITS-1){1'b0}}, ops_lt};
            ALU_FN_SLTU:   out = {{(P_NBITS-1){1'b0}}, ops_ltu};
            ALU_FN_AND:    out = in0 & in1;
            ALU_FN_XOR:    out = in0 ^ in1;
            ALU_FN_NOR:    out = ~(in0 | in1);
            ALU_FN_SRL:    out = in0 >> w_shamt;
            ALU_FN_SRA:    out = $unsigned($signed(in0) >>> w_shamt);
            ALU_FN_CP_OP0: out = in0;
            ALU_FN_CP_OP1: out = in1;
`ifdef ALU_SUBWORD_EN
            ALU_FN_PADDB:  out = w_paddb;
            ALU_FN_PADDH:  out = w_paddh;
            ALU_FN_PSUBB:  out = w_psubb;
            ALU_FN_PSUBH:  out = w_psubh;
`endif
            default:       out = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/proc_alu_stream_pipe.sv
`default_nettype none
// ============================================================================
// Module   : proc_alu_stream_pipe
// Purpose  : Fully elastic val/rdy wrapper around proc_alu_core.
//            Stage 0 registers the request {fn,in0,in1}; the ALU sits between
//            stage 0 and stage 1; stages 1..P_NSTAGES-1 register results.
//            Latency P_NSTAGES cycles, throughput one per cycle, FIFO order.
// Ports    : clk, reset (sync, active-high)
//            istream_val/rdy/msg  request  {fn[5:0], in0, in1}
//            ostream_val/rdy/msg  response {ops_eq, ops_lt, ops_ltu, out}
// Config   : ALU_SUBWORD_EN (forwarded to proc_alu_core) enables packed ops.
// Revision : 1.0 - initial release
// ============================================================================
module proc_alu_stream_pipe
    import proc_alu_pkg::*;
#(
    parameter int P_NBITS   = 32,
    parameter int P_NSTAGES = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            istream_val,
    output logic                            istream_rdy,
    input  logic [2*P_NBITS+ALU_FN_W-1:0]   istream_msg,
    output logic                            ostream_val,
    input  logic                            ostream_rdy,
    output logic [P_NBITS+2:0]              ostream_msg
);

    localparam int c_REQ_W  = req_msg_w(P_NBITS);
    localparam int c_RESP_W = resp_msg_w(P_NBITS);

    logic [c_REQ_W-1:0]                     r_req;
    logic [P_NSTAGES-1:0]                   r_valid;
    logic [P_NSTAGES-1:0]                   w_go;
    logic [P_NSTAGES-1:0]                   w_load;
    // Element 0 is the ALU output; element k>0 is the stage-k result register.
    logic [P_NSTAGES-1:0][c_RESP_W-1:0]     w_stage_resp;

    logic [ALU_FN_W-1:0]                    w_fn;
    logic [P_NBITS-1:0]                     w_in0;
    logic [P_NBITS-1:0]                     w_in1;
    logic [P_NBITS-1:0]                     w_alu_out;
    logic                                   w_eq;
    logic                                   w_lt;
    logic                                   w_ltu;

    // Advance chain: a stage may move when its successor is empty or moving.
    // Only ostream_rdy feeds this chain, so ostream_rdy -> istream_rdy is the
    // sole combinational path through the block.
    always_comb begin
        w_go = '0;
        w_go[P_NSTAGES-1] = ostream_rdy;
        for (int k = P_NSTAGES - 2; k >= 0; k--) begin
            w_go[k] = !r_valid[k+1] | w_go[k+1];
        end
    end

    assign istream_rdy = (!r_valid[0] | w_go[0]) & !reset;

    always_comb begin
        w_load = '0;
        w_load[0] = istream_val & istream_rdy;
        for (int k = 1; k < P_NSTAGES; k++) begin
            w_load[k] = r_valid[k-1] & w_go[k-1];
        end
    end

    // A loading stage becomes valid; a draining stage with nothing arriving
    // empties; a stalled stage (go low) keeps its state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
        end else begin
            for (int k = 0; k < P_NSTAGES; k++) begin
                if (w_load[k]) begin
                    r_valid[k] <= 1'b1;
                end else if (w_go[k]) begin
                    r_valid[k] <= 1'b0;
                end
            end
        end
    end

    // Payload registers are intentionally left unreset.
    always_ff @(posedge clk) begin
        if (w_load[0]) begin
            r_req <= istream_msg;
        end
    end

    assign w_fn  = r_req[2*P_NBITS +: ALU_FN_W];
    assign w_in0 = r_req[P_NBITS +: P_NBITS];
    assign w_in1 = r_req[0 +: P_NBITS];

    proc_alu_core #(
        .P_NBITS (P_NBITS)
    ) u_core (
        .in0     (w_in0),
        .in1     (w_in1),
        .fn      (w_fn),
        .out     (w_alu_out),
        .ops_eq  (w_eq),
        .ops_lt  (w_lt),
        .ops_ltu (w_ltu)
    );

    assign w_stage_resp[0] = {pack_flags(w_eq, w_lt, w_ltu), w_alu_out};

    for (genvar k = 1; k < P_NSTAGES; k++) begin : g_stage
        logic [c_RESP_W-1:0] r_resp;

        always_ff @(posedge clk) begin
            if (w_load[k]) begin
                r_resp <= w_stage_resp[k-1];
            end
        end

        assign w_stage_resp[k] = r_resp;
    end

    assign ostream_val = r_valid[P_NSTAGES-1];
    // Payload regs are unreset, so gate the message to keep it clean when idle.
    assign ostream_msg = ostream_val ? w_stage_resp[P_NSTAGES-1] : '0;

endmodule
`default_nettype wire

// File: tb/tb_proc_alu_stream_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_proc_alu_stream_pipe
// Purpose  : Directed self-checking bench for proc_alu_stream_pipe.
//            Main instance: 32-bit, 2 stages. Extra instances: 32-bit/1 stage
//            and 64-bit/3 stages for latency/width coverage.
// Config   : ALU_SUBWORD_EN selects expected results for packed fn codes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_proc_alu_stream_pipe;
    import proc_alu_pkg::*;

    logic         clk;
    logic         reset;

    logic         in_val,  in_rdy,  out_val,  out_rdy;
    logic [69:0]  in_msg;
    logic [34:0]  out_msg;

    logic         in1_val, in1_rdy, out1_val, out1_rdy;
    logic [69:0]  in1_msg;
    logic [34:0]  out1_msg;

    logic         in3_val, in3_rdy, out3_val, out3_rdy;
    logic [133:0] in3_msg;
    logic [66:0]  out3_msg;

    int n_checks = 0;
    int n_fail   = 0;

    proc_alu_stream_pipe #(.P_NBITS(32), .P_NSTAGES(2)) dut (
        .clk(clk), .reset(reset),
        .istream_val(in_val), .istream_rdy(in_rdy), .istream_msg(in_msg),
        .ostream_val(out_val), .ostream_rdy(out_rdy), .ostream_msg(out_msg)
    );

    proc_alu_stream_pipe #(.P_NBITS(32), .P_NSTAGES(1)) dut_n1 (
        .clk(clk), .reset(reset),
        .istream_val(in1_val), .istream_rdy(in1_rdy), .istream_msg(in1_msg),
        .ostream_val(out1_val), .ostream_rdy(out1_rdy), .ostream_msg(out1_msg)
    );

    proc_alu_stream_pipe #(.P_NBITS(64), .P_NSTAGES(3)) dut_n3 (
        .clk(clk), .reset(reset),
        .istream_val(in3_val), .istream_rdy(in3_rdy), .istream_msg(in3_msg),
        .ostream_val(out3_val), .ostream_rdy(out3_rdy), .ostream_msg(out3_msg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Presents one op with the sink ready; entry/exit just after a posedge.
    task automatic single_op(input string tag, input logic [5:0] fn,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [34:0] exp);
        int lat;
        in_val  = 1'b1;
        in_msg  = {fn, a, b};
        out_rdy = 1'b1;
        #1;
        check({tag, "_rdy"}, in_rdy, 1'b1);
        @(posedge clk); #1;
        in_val = 1'b0;
        in_msg = '0;
        lat    = 1;
        while (!out_val && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, lat, 2);
        check({tag, "_msg"}, out_msg, exp);
        @(posedge clk); #1;
        check({tag, "_drain"}, out_val, 1'b0);
    endtask

    // First burst: ADD, SUB, SRA, SLTU
    logic [5:0]  t_fn  [4] = '{ALU_FN_ADD, ALU_FN_SUB, ALU_FN_SRA, ALU_FN_SLTU};
    logic [31:0] t_a   [4] = '{32'd5, 32'd0, 32'h8000_0000, 32'd1};
    logic [31:0] t_b   [4] = '{32'd3, 32'd1, 32'd4, 32'd2};
    logic [34:0] t_exp [4] = '{{3'b000, 32'd8},
                               {3'b011, 32'hFFFF_FFFF},
                               {3'b010, 32'hF800_0000},
                               {3'b011, 32'd1}};

    // Back-pressure burst
    logic [5:0]  b_fn  [8] = '{ALU_FN_ADD, ALU_FN_SUB, ALU_FN_AND, ALU_FN_OR,
                               ALU_FN_XOR, ALU_FN_SLL, ALU_FN_SRL, ALU_FN_NOR};
    logic [31:0] b_a   [8] = '{32'd10, 32'd7, 32'hF0F0_F0F0, 32'h0000_FF00,
                               32'hAAAA_5555, 32'd1, 32'h8000_0000, 32'd0};
    logic [31:0] b_b   [8] = '{32'd20, 32'd9, 32'h0FF0_0FF0, 32'h0000_00FF,
                               32'hFFFF_0000, 32'd31, 32'd31, 32'd0};
    logic [34:0] b_exp [8] = '{{3'b011, 32'd30},
                               {3'b011, 32'hFFFF_FFFE},
                               {3'b010, 32'h00F0_00F0},
                               {3'b000, 32'h0000_FFFF},
                               {3'b011, 32'h5555_5555},
                               {3'b011, 32'h8000_0000},
                               {3'b010, 32'd1},
                               {3'b100, 32'hFFFF_FFFF}};

    initial begin
        int tx, rx, occ;
        logic acc, emit, exp_rdy;

        reset   = 1'b1;
        in_val  = 1'b0; in_msg  = '0; out_rdy  = 1'b1;
        in1_val = 1'b0; in1_msg = '0; out1_rdy = 1'b1;
        in3_val = 1'b0; in3_msg = '0; out3_rdy = 1'b1;

        // ---- reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_oval", out_val, 1'b0);
        check("rst_omsg", out_msg, 35'd0);
        check("rst_irdy", in_rdy, 1'b0);
        reset = 1'b0;
        #1;
        check("post_rst_irdy", in_rdy, 1'b1);
        @(posedge clk); #1;

        // ---- four back-to-back ops, sink always ready, latency 2
        for (int t = 0; t < 6; t++) begin
            if (t < 4) begin
                in_val = 1'b1;
                in_msg = {t_fn[t], t_a[t], t_b[t]};
            end else begin
                in_val = 1'b0;
                in_msg = '0;
            end
            #1;
            check("burst_irdy", in_rdy, 1'b1);
            check("burst_oval", out_val, (t >= 2));
            if (t >= 2) check("burst_msg", out_msg, t_exp[t-2]);
            @(posedge clk); #1;
        end

        // ---- flag behaviour and fn decoding
        single_op("cp_op0", ALU_FN_CP_OP0, 32'hFFFF_FFFF, 32'd1, {3'b010, 32'hFFFF_FFFF});
        single_op("fn63",   6'd63,         32'hFFFF_FFFF, 32'd1, {3'b010, 32'd0});
        single_op("slt",    ALU_FN_SLT,    32'hFFFF_FFFF, 32'd1, {3'b010, 32'd1});
        single_op("sltu",   ALU_FN_SLTU,   32'hFFFF_FFFF, 32'd1, {3'b010, 32'd0});
        single_op("cp_op1", ALU_FN_CP_OP1, 32'd7, 32'd7, {3'b100, 32'd7});
`ifdef ALU_SUBWORD_EN
        single_op("paddb", ALU_FN_PADDB, 32'h01FF_7F80, 32'h0101_0101, {3'b000, 32'h0200_8081});
        single_op("psubh", ALU_FN_PSUBH, 32'h0000_0001, 32'h0001_0002, {3'b011, 32'hFFFF_FFFF});
`else
        single_op("paddb", ALU_FN_PADDB, 32'h01FF_7F80, 32'h0101_0101, {3'b000, 32'd0});
        single_op("psubh", ALU_FN_PSUBH, 32'h0000_0001, 32'h0001_0002, {3'b011, 32'd0});
`endif

        // ---- eight ops with sink ready toggling 1,0,1,0...
        tx = 0; rx = 0; occ = 0;
        for (int cyc = 0; cyc < 60 && rx < 8; cyc++) begin
            out_rdy = (cyc % 2 == 0);
            if (tx < 8) begin
                in_val = 1'b1;
                in_msg = {b_fn[tx], b_a[tx], b_b[tx]};
            end else begin
                in_val = 1'b0;
                in_msg = '0;
            end
            #1;
            exp_rdy = !(occ == 2 && !out_rdy);
            check("b2b_irdy", in_rdy, exp_rdy);
            if (occ == 0) check("b2b_empty_oval", out_val, 1'b0);
            acc  = in_val && in_rdy;
            emit = out_val && out_rdy;
            if (emit) begin
                if (rx < 8) check("b2b_msg", out_msg, b_exp[rx]);
                else        check("b2b_extra", out_val, 1'b0);
                rx++;
            end
            if (acc) tx++;
            occ = occ + int'(acc) - int'(emit);
            @(posedge clk); #1;
        end
        in_val = 1'b0; in_msg = '0; out_rdy = 1'b1;
        check("b2b_rx_count", rx, 8);
        check("b2b_tx_count", tx, 8);
        #1;
        check("b2b_drained", out_val, 1'b0);
        @(posedge clk); #1;

        // ---- reset with two requests in flight
        out_rdy = 1'b0;
        in_val  = 1'b1;
        in_msg  = {ALU_FN_ADD, 32'd9, 32'd9};
        @(posedge clk); #1;
        in_msg  = {ALU_FN_SUB, 32'd9, 32'd2};
        @(posedge clk); #1;
        in_val  = 1'b0;
        in_msg  = '0;
        #1;
        check("mid_full_oval", out_val, 1'b1);
        check("mid_full_irdy", in_rdy, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_oval", out_val, 1'b0);
        check("mid_rst_omsg", out_msg, 35'd0);
        check("mid_rst_irdy", in_rdy, 1'b0);
        reset = 1'b0;
        single_op("post_mid_add", ALU_FN_ADD, 32'd1, 32'd1, {3'b100, 32'd2});

        // ---- single-stage instance: latency 1
        in1_val = 1'b1;
        in1_msg = {ALU_FN_ADD, 32'd5, 32'd3};
        #1;
        check("n1_c0_oval", out1_val, 1'b0);
        @(posedge clk); #1;
        in1_val = 1'b0;
        in1_msg = '0;
        check("n1_c1_oval", out1_val, 1'b1);
        check("n1_c1_msg", out1_msg, {3'b000, 32'd8});
        @(posedge clk); #1;
        check("n1_c2_oval", out1_val, 1'b0);

        // ---- 64-bit three-stage instance: latency 3, carry into bit 32
        in3_val = 1'b1;
        in3_msg = {ALU_FN_ADD, 64'h0000_0000_FFFF_FFFF, 64'd1};
        @(posedge clk); #1;
        in3_val = 1'b0;
        in3_msg = '0;
        check("n3_c1_oval", out3_val, 1'b0);
        @(posedge clk); #1;
        check("n3_c2_oval", out3_val, 1'b0);
        @(posedge clk); #1;
        check("n3_c3_oval", out3_val, 1'b1);
        check("n3_c3_msg", out3_msg, {3'b000, 64'h0000_0001_0000_0000});
        @(posedge clk); #1;
        check("n3_c4_oval", out3_val, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
